g_exor: RTL and testbench
=========================

// Module: g_exor
// PURPOSE
//   Bitwise 2-input exclusive-OR with a combinational result and a registered,
//   qualified copy of it. Also produces per-sample parity, a mismatch popcount
//   and a saturating count of mismatching samples.
//   Used wherever operand equality or difference must be flagged, such as
//   compare and checker paths.
// PARAMETERS
//   WIDTH     1    operand width in bits (>=1)
//   CNT_W     16   width of the mismatch-sample counter
// PORTS
//   clk       in   1                  single clock, all registers on rising edge
//   rst       in   1                  synchronous, active-high reset
//   a         in   WIDTH              operand A
//   b         in   WIDTH              operand B
//   in_valid  in   1                  a/b form a sample to register and count
//   y         out  WIDTH              combinational a ^ b
//   y_q       out  WIDTH              registered a ^ b
//   out_valid out  1                  y_q/par_q/diff_q hold a valid sample
//   par_q     out  1                  registered reduction XOR of (a ^ b)
//   diff_q    out  $clog2(WIDTH+1)    registered popcount of (a ^ b)
//   mis_cnt   out  CNT_W              count of valid samples with a != b
// BEHAVIOUR
//   Interface: one clock (clk); reset rst is synchronous, active-high.
//   Combinational output y:
//     - y = a ^ b, bitwise, zero latency, purely combinational.
//     - Independent of clk, rst and in_valid; correct even when no clock toggles.
//     - Inputs 00->0, 01->1, 10->1, 11->0 per bit.
//   Reset: on rising clk with rst=1, all registered outputs clear:
//     y_q=0, out_valid=0, par_q=0, diff_q=0, mis_cnt=0.
//     Reset wins over in_valid in the same cycle.
//   Registered path (latency 1, no backpressure):
//     - When in_valid=1 at edge N, then at edge N:
//       y_q <= a^b, par_q <= ^(a^b), diff_q <= popcount(a^b), out_valid <= 1.
//     - When in_valid=0, out_valid <= 0; y_q/par_q/diff_q hold their last values.
//   Counter:
//     - mis_cnt increments by 1 on each edge with in_valid=1 and (a^b)!=0.
//     - Saturates at 2^CNT_W-1; never wraps.
//     - Only rst clears it.
//   Reset mid-stream:
//     - Registered state is discarded at the reset edge.
//     - The first sample after rst deasserts is treated as a fresh sample.
//   X-free: no latches; all registers are reset.
// TESTING
//   1. WIDTH=1, no clock; a/b stepped 00,10,11,01,10,00,01 with 10 ns holds
//      -> y = 0,1,0,1,1,0,1, settling within the same delta.
//   2. Hold rst=1 for 2 cycles with in_valid=1, a=1, b=0
//      -> y_q=0, out_valid=0, mis_cnt=0 throughout; y=1 combinationally.
//   3. WIDTH=8; send a=8'hF0, b=8'h0F (valid), then a=8'hAA, b=8'hAA
//      -> after cycle 1: y_q=8'hFF, par_q=0, diff_q=8, mis_cnt=1.
//      -> after cycle 2: y_q=0, diff_q=0, mis_cnt=1.
//   4. Drop in_valid after one sample
//      -> out_valid falls next edge; y_q holds; mis_cnt unchanged.
//   5. CNT_W=2; send 5 mismatching valid samples -> mis_cnt = 1,2,3,3,3.
//   6. Assert rst for one cycle mid-stream, then resume
//      -> all registered outputs 0 the edge after rst; counting restarts at 1.

Source files
------------

// File: rtl/g_exor.sv
// Bitwise XOR of two operands: combinational result plus a registered, qualified
// copy with parity, mismatch popcount and a saturating mismatch-sample counter.
module g_exor #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16,
    localparam int DW   = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_in_valid,
    output logic [WIDTH-1:0] o_y,
    output logic [WIDTH-1:0] o_y_q,
    output logic             o_out_valid,
    output logic             o_par_q,
    output logic [DW-1:0]    o_diff_q,
    output logic [CNT_W-1:0] o_mis_cnt
);

    logic [WIDTH-1:0] w_x;
    logic [DW-1:0]    w_pop;
    logic             w_par;
    logic             w_sat;

    logic [WIDTH-1:0] r_y_q;
    logic             r_out_valid;
    logic             r_par_q;
    logic [DW-1:0]    r_diff_q;
    logic [CNT_W-1:0] r_mis_cnt;

    // y is a pure function of the operands, never touched by clock or reset
    assign w_x   = i_a ^ i_b;
    assign o_y   = w_x;
    assign w_par = ^w_x;
    assign w_sat = &r_mis_cnt;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++)
            w_pop = w_pop + DW'(w_x[i]);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_y_q       <= '0;
            r_out_valid <= 1'b0;
            r_par_q     <= 1'b0;
            r_diff_q    <= '0;
            r_mis_cnt   <= '0;
        end else begin
            r_out_valid <= i_in_valid;
            // data registers hold their last sample while idle
            if (i_in_valid) begin
                r_y_q    <= w_x;
                r_par_q  <= w_par;
                r_diff_q <= w_pop;
                if ((|w_x) && !w_sat)
                    r_mis_cnt <= r_mis_cnt + CNT_W'(1);
            end
        end
    end

    assign o_y_q       = r_y_q;
    assign o_out_valid = r_out_valid;
    assign o_par_q     = r_par_q;
    assign o_diff_q    = r_diff_q;
    assign o_mis_cnt   = r_mis_cnt;

endmodule

// File: tb/tb_g_exor.sv
// Bench for g_exor: table vectors, directed multi-cycle sequences and a random
// run checked against a behavioural model, on 1-bit, 8-bit and narrow-counter instances.
module tb_g_exor;

    logic clk = 1'b0;
    bit   clk_en = 1'b0;
    initial begin
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    logic       rst, vld;
    logic [7:0] a8, b8;

    logic        yA, yqA, ovA, parA, diffA;
    logic [15:0] cntA;
    logic [7:0]  yB, yqB, yC, yqC;
    logic        ovB, parB, ovC, parC;
    logic [3:0]  diffB, diffC;
    logic [15:0] cntB;
    logic [1:0]  cntC;

    g_exor #(.WIDTH(1), .CNT_W(16)) u_a (
        .i_clk(clk), .i_rst(rst), .i_a(a8[0:0]), .i_b(b8[0:0]), .i_in_valid(vld),
        .o_y(yA), .o_y_q(yqA), .o_out_valid(ovA), .o_par_q(parA),
        .o_diff_q(diffA), .o_mis_cnt(cntA));

    g_exor #(.WIDTH(8), .CNT_W(16)) u_b (
        .i_clk(clk), .i_rst(rst), .i_a(a8), .i_b(b8), .i_in_valid(vld),
        .o_y(yB), .o_y_q(yqB), .o_out_valid(ovB), .o_par_q(parB),
        .o_diff_q(diffB), .o_mis_cnt(cntB));

    g_exor #(.WIDTH(8), .CNT_W(2)) u_c (
        .i_clk(clk), .i_rst(rst), .i_a(a8), .i_b(b8), .i_in_valid(vld),
        .o_y(yC), .o_y_q(yqC), .o_out_valid(ovC), .o_par_q(parC),
        .o_diff_q(diffC), .o_mis_cnt(cntC));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: what the registered outputs should hold after each edge
    logic [7:0] m_yq = '0;
    logic       m_vld = 1'b0;
    int         m_diff = 0, m_cnt = 0;
    logic       mA_yq = 1'b0;
    int         mA_cnt = 0;

    function automatic int sat(input int c, input int m);
        return (c > m) ? m : c;
    endfunction

    task automatic model_edge();
        logic [7:0] x;
        if (rst) begin
            m_yq = '0; m_vld = 1'b0; m_diff = 0; m_cnt = 0;
            mA_yq = 1'b0; mA_cnt = 0;
        end else begin
            m_vld = vld;
            if (vld) begin
                x      = a8 ^ b8;
                m_yq   = x;
                m_diff = $countones(x);
                if (x != 0) m_cnt++;
                mA_yq = x[0];
                if (x[0]) mA_cnt++;
            end
        end
    endtask

    task automatic check_all();
        chk("A.y",         yA,    a8[0] ^ b8[0]);
        chk("A.y_q",       yqA,   mA_yq);
        chk("A.out_valid", ovA,   m_vld);
        chk("A.par_q",     parA,  mA_yq);
        chk("A.diff_q",    diffA, mA_yq);
        chk("A.mis_cnt",   cntA,  sat(mA_cnt, 65535));
        chk("B.y",         yB,    a8 ^ b8);
        chk("B.y_q",       yqB,   m_yq);
        chk("B.out_valid", ovB,   m_vld);
        chk("B.par_q",     parB,  m_diff % 2);
        chk("B.diff_q",    diffB, m_diff);
        chk("B.mis_cnt",   cntB,  sat(m_cnt, 65535));
        chk("C.y_q",       yqC,   m_yq);
        chk("C.out_valid", ovC,   m_vld);
        chk("C.par_q",     parC,  m_diff % 2);
        chk("C.diff_q",    diffC, m_diff);
        chk("C.mis_cnt",   cntC,  sat(m_cnt, 3));
    endtask

    task automatic edge_chk();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    typedef struct { logic a; logic b; logic ey; } v1_t;
    typedef struct { logic [7:0] a; logic [7:0] b; logic [7:0] ey; logic epar; logic [3:0] ediff; } v8_t;

    v1_t t1[7];
    v8_t t8[6];
    int  sat_exp[5];

    initial begin
        t1[0] = '{1'b0, 1'b0, 1'b0};
        t1[1] = '{1'b1, 1'b0, 1'b1};
        t1[2] = '{1'b1, 1'b1, 1'b0};
        t1[3] = '{1'b0, 1'b1, 1'b1};
        t1[4] = '{1'b1, 1'b0, 1'b1};
        t1[5] = '{1'b0, 1'b0, 1'b0};
        t1[6] = '{1'b0, 1'b1, 1'b1};
        t8[0] = '{8'hF0, 8'h0F, 8'hFF, 1'b0, 4'd8};
        t8[1] = '{8'hAA, 8'h55, 8'hFF, 1'b0, 4'd8};
        t8[2] = '{8'hAA, 8'hAA, 8'h00, 1'b0, 4'd0};
        t8[3] = '{8'h12, 8'h34, 8'h26, 1'b1, 4'd3};
        t8[4] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 4'd8};
        t8[5] = '{8'h81, 8'h18, 8'h99, 1'b0, 4'd4};
        sat_exp = '{1, 2, 3, 3, 3};

        rst = 1'b0; vld = 1'b0; a8 = '0; b8 = '0;

        // combinational path with no clock running
        foreach (t1[i]) begin
            a8[0] = t1[i].a; b8[0] = t1[i].b;
            #1 chk("t1.y", yA, t1[i].ey);
            #9;
        end

        clk_en = 1'b1;

        // reset dominates a valid mismatching sample
        rst = 1'b1; vld = 1'b1; a8 = 8'h01; b8 = 8'h00;
        repeat (2) begin
            edge_chk();
            chk("rst.y_q", yqA, 0); chk("rst.out_valid", ovA, 0);
            chk("rst.mis_cnt", cntA, 0); chk("rst.y", yA, 1);
        end
        rst = 1'b0;

        foreach (t8[i]) begin
            a8 = t8[i].a; b8 = t8[i].b; vld = 1'b1;
            #1 chk("tab.y", yB, t8[i].ey);
            edge_chk();
            chk("tab.y_q", yqB, t8[i].ey);
            chk("tab.par_q", parB, t8[i].epar);
            chk("tab.diff_q", diffB, t8[i].ediff);
        end

        rst = 1'b1; edge_chk(); rst = 1'b0;
        a8 = 8'hF0; b8 = 8'h0F; vld = 1'b1; edge_chk();
        chk("s3.y_q", yqB, 8'hFF); chk("s3.par_q", parB, 0);
        chk("s3.diff_q", diffB, 8); chk("s3.mis_cnt", cntB, 1);
        a8 = 8'hAA; b8 = 8'hAA; edge_chk();
        chk("s3b.y_q", yqB, 0); chk("s3b.diff_q", diffB, 0); chk("s3b.mis_cnt", cntB, 1);

        // idle cycle holds data, drops valid
        a8 = 8'hF0; b8 = 8'h00; edge_chk();
        vld = 1'b0; a8 = 8'h3C; edge_chk();
        chk("s4.out_valid", ovB, 0); chk("s4.y_q", yqB, 8'hF0); chk("s4.mis_cnt", cntB, 2);

        rst = 1'b1; edge_chk(); rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a8 = 8'(i + 1); b8 = 8'h00; vld = 1'b1;
            edge_chk();
            chk("s5.mis_cnt", cntC, sat_exp[i]);
        end

        a8 = 8'h05; b8 = 8'h00; edge_chk();
        rst = 1'b1; a8 = 8'h07; edge_chk();
        chk("s6.y_q", yqB, 0); chk("s6.out_valid", ovB, 0); chk("s6.par_q", parB, 0);
        chk("s6.diff_q", diffB, 0); chk("s6.mis_cnt", cntB, 0);
        rst = 1'b0; a8 = 8'hFF; b8 = 8'h01; edge_chk();
        chk("s6b.mis_cnt", cntB, 1); chk("s6b.mis_cntC", cntC, 1);
        chk("s6b.out_valid", ovB, 1); chk("s6b.y_q", yqB, 8'hFE);

        for (int i = 0; i < 300; i++) begin
            a8  = 8'($urandom);
            b8  = ($urandom_range(0, 3) == 0) ? a8 : 8'($urandom);
            vld = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 49) == 0);
            edge_chk();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
